program_counter_ras: RTL

Parametrised program-counter unit for the multicycle CPU, replacing the fixed 32-bit load-only PC register. It holds the fetch address and selects the next PC from several sources: sequential, relative branch, absolute jump, register, return and exception. It also keeps a small return-address stack (RAS) for call/return and an exception PC (EPC) with a cause code. It sits between the control FSM (which supplies `pc_write`, `pc_src` and `call`) and the instruction-memory address port.

---
 rtl/program_counter_ras.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/program_counter_ras.sv
// rtl/program_counter_ras.sv - program counter with next-PC select, return-address stack and exception PC
//
// Holds the fetch address and selects the next PC on pc_write from one of:
// sequential, relative branch, absolute jump, register, return (RAS top) or
// exception vector. Calls push PC+INC onto a circular return-address stack;
// exceptions capture the faulting PC and a cause code.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous active-high reset
//   pc_write     in   1      update enable; 0 holds all state
//   pc_src       in   3      0 seq, 1 branch, 2 jump, 3 reg, 4 return, 5 exception, 6/7 hold
//   branch_off   in   WIDTH  signed byte offset added to pc
//   jump_target  in   WIDTH  absolute target for jump
//   reg_target   in   WIDTH  register target for reg
//   call         in   1      push pc+INC (jump/reg only, not on exception)
//   pc           out  WIDTH  current PC
//   epc          out  WIDTH  PC of the last excepting instruction
//   exc_cause    out  2      0 none, 1 requested, 2 misaligned, 3 RAS underflow
//   ras_empty    out  1      stack count == 0
//   ras_full     out  1      stack count == RAS_DEPTH
//   ras_overflow out  1      sticky: a push overwrote the oldest entry

module program_counter_ras #(
   parameter int                WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0080,
   parameter int                INC          = 4,
   parameter int                RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic [2:0]       pc_src,
   input  logic [WIDTH-1:0] branch_off,
   input  logic [WIDTH-1:0] jump_target,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             call,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] epc,
   output logic [1:0]       exc_cause,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
   localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(RAS_DEPTH);

   localparam logic [2:0] SRC_SEQ    = 3'd0;
   localparam logic [2:0] SRC_BRANCH = 3'd1;
   localparam logic [2:0] SRC_JUMP   = 3'd2;
   localparam logic [2:0] SRC_REG    = 3'd3;
   localparam logic [2:0] SRC_RET    = 3'd4;
   localparam logic [2:0] SRC_EXC    = 3'd5;

   localparam logic [1:0] CAUSE_REQ       = 2'd1;
   localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;
   localparam logic [1:0] CAUSE_UNDERFLOW = 2'd3;

   // Circular stack: wr_ptr is the next slot to write, so the top lives at
   // wr_ptr-1. On a full push the write lands on the oldest entry, which is
   // exactly the overwrite-oldest behaviour wanted.
   logic [WIDTH-1:0] entries [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] ras_count;

   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] next_pc;
   logic             take_exc;
   logic [1:0]       cause;
   logic             do_push;
   logic             do_pop;
   logic             target_src;

   assign top_idx   = wr_ptr - PTR_W'(1);
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == DEPTH_C);

   always_comb begin
      seq_pc     = pc + INC_W;
      next_pc    = pc;
      take_exc   = 1'b0;
      cause      = 2'd0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      target_src = (pc_src == SRC_BRANCH) || (pc_src == SRC_JUMP) || (pc_src == SRC_REG);

      case (pc_src)
         SRC_SEQ:    next_pc = seq_pc;
         SRC_BRANCH: next_pc = pc + branch_off;
         SRC_JUMP:   next_pc = jump_target;
         SRC_REG:    next_pc = reg_target;
         SRC_RET: begin
            if (ras_count == '0) begin
               take_exc = 1'b1;
               cause    = CAUSE_UNDERFLOW;
            end else begin
               next_pc = entries[top_idx];
               do_pop  = 1'b1;
            end
         end
         SRC_EXC: begin
            take_exc = 1'b1;
            cause    = CAUSE_REQ;
         end
         default:    next_pc = pc;   // reserved selects hold everything
      endcase

      if (target_src && ((next_pc & ALIGN_MASK) != '0)) begin
         take_exc = 1'b1;
         cause    = CAUSE_MISALIGN;
      end

      // A faulting call must not leave a stale return address behind.
      if (!take_exc && call && ((pc_src == SRC_JUMP) || (pc_src == SRC_REG)))
         do_push = 1'b1;

      if (take_exc)
         next_pc = EXC_PC;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc           <= RESET_VECTOR;
         epc          <= '0;
         exc_cause    <= 2'd0;
         wr_ptr       <= '0;
         ras_count    <= '0;
         ras_overflow <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++)
            entries[i] <= '0;
      end else if (pc_write) begin
         pc <= next_pc;
         if (take_exc) begin
            epc       <= pc;
            exc_cause <= cause;
         end
         if (do_push) begin
            entries[wr_ptr] <= seq_pc;
            wr_ptr          <= wr_ptr + PTR_W'(1);
            if (ras_count == DEPTH_C)
               ras_overflow <= 1'b1;
            else
               ras_count <= ras_count + CNT_W'(1);
         end else if (do_pop) begin
            wr_ptr    <= top_idx;
            ras_count <= ras_count - CNT_W'(1);
         end
      end
   end

endmodule
